// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the banked data memory:
//               controller states, read-result formats, access-size codes.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Controller states
    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        SPLIT = 2'd2
    } dmemState_e;

    // How ReadData is assembled from the two bank read registers
    typedef enum logic [2:0] {
        FMT_ZERO    = 3'd0,   // rejected read / after reset
        FMT_BYTE_E  = 3'd1,   // {00, even byte}
        FMT_BYTE_O  = 3'd2,   // {00, odd byte}
        FMT_WORD_EO = 3'd3,   // aligned word: even byte is MSB
        FMT_WORD_OE = 3'd4,   // misaligned word: odd byte is MSB
        FMT_HOLD    = 3'd5    // frozen copy while a misaligned read is in flight
    } rdFmt_e;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    // Bank index width for a given byte capacity (at least one bit)
    function automatic int idxWidth(input int depthBytes);
        return (depthBytes > 2) ? $clog2(depthBytes / 2) : 1;
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_bank.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bank
// Description : Byte-wide RAM bank with synchronous write and a registered,
//               enable-gated read port. The read register holds its value
//               until the next read; the array itself is never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bank #(
    parameter int ENTRIES = 128,
    parameter int IDX_W   = 7
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             WriteEn,
    input  logic             ReadEn,
    input  logic [IDX_W-1:0] Index,
    input  logic [7:0]       WriteByte,
    output logic [7:0]       ReadByte
);

    logic [7:0] r_mem [ENTRIES];
    logic [7:0] r_readByte;

    // Storage array write port (no reset: contents survive Reset_n)
    always_ff @(posedge Clock) begin
        if (WriteEn) begin
            r_mem[Index] <= WriteByte;
        end
    end

    // Registered read, updated only when a read is requested
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_readByte <= 8'h00;
        end else if (ReadEn) begin
            r_readByte <= r_mem[Index];
        end
    end

    assign ReadByte = r_readByte;

endmodule : dmem_bank
`default_nettype wire

// File: rtl/banked_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : banked_data_memory
// Description : Byte-addressable data memory built from an even and an odd
//               byte bank. Big-endian byte/word access, single-cycle aligned
//               accesses, two-cycle misaligned words, range checking, and an
//               optional zero-fill sweep after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module banked_data_memory
    import dmem_pkg::*;
#(
    parameter int    ADDR_W         = 16,
    parameter int    DEPTH_BYTES    = 256,
    parameter bit    CLEAR_ON_RESET = 1'b1,
    // Byte image preloaded into the banks by the integration flow; only
    // meaningful when CLEAR_ON_RESET is 0.
    parameter string INIT_FILE      = ""
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Req,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic              Size,
    input  logic [ADDR_W-1:0] Adresa,
    input  logic [15:0]       WriteData,
    output logic              Ready,
    output logic [15:0]       ReadData,
    output logic              ReadValid,
    output logic              AddrError
);

    localparam int                  c_idxW       = idxWidth(DEPTH_BYTES);
    localparam int                  c_entries    = DEPTH_BYTES / 2;
    localparam logic [c_idxW-1:0]   c_lastIdx    = c_idxW'(c_entries - 1);
    localparam logic [ADDR_W:0]     c_depth      = (ADDR_W + 1)'(DEPTH_BYTES);
    localparam dmemState_e          c_resetState = CLEAR_ON_RESET ? INIT : IDLE;

    dmemState_e        r_state;
    dmemState_e        w_nextState;
    logic [c_idxW-1:0] r_clearIdx;
    logic              r_ready;
    logic              r_readValid;
    logic              r_addrError;
    rdFmt_e            r_fmt;
    logic [15:0]       r_holdData;
    logic [c_idxW-1:0] r_splitIdx;
    logic [7:0]        r_splitByte;
    logic              r_splitRead;

    logic              w_accept;
    logic              w_doAccess;
    logic              w_isWrite;
    logic              w_isRead;
    logic              w_isWord;
    logic              w_oddAddr;
    logic              w_reject;
    logic              w_misaligned;
    logic [ADDR_W:0]   w_addrExt;
    logic [ADDR_W:0]   w_addrLast;
    logic [c_idxW-1:0] w_wordIdx;

    logic              w_weE;
    logic              w_weO;
    logic              w_reE;
    logic              w_reO;
    logic [c_idxW-1:0] w_idxE;
    logic [c_idxW-1:0] w_idxO;
    logic [7:0]        w_wdE;
    logic [7:0]        w_wdO;
    logic [7:0]        w_rdE;
    logic [7:0]        w_rdO;
    logic [15:0]       w_readData;

    // Request decode and range check (last byte touched must be in range)
    always_comb begin
        w_accept     = Req & r_ready;
        w_doAccess   = w_accept & (MemWrite | MemRead);
        w_isWrite    = MemWrite;
        w_isRead     = MemRead & ~MemWrite;
        w_isWord     = (Size == SIZE_WORD);
        w_oddAddr    = Adresa[0];
        w_addrExt    = {1'b0, Adresa};
        w_addrLast   = w_addrExt + (ADDR_W + 1)'(w_isWord);
        w_reject     = (w_addrLast >= c_depth);
        w_misaligned = w_isWord & w_oddAddr;
        w_wordIdx    = Adresa[c_idxW:1];
    end

    // FSM state register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= c_resetState;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            INIT:    if (r_clearIdx == c_lastIdx) w_nextState = IDLE;
            IDLE:    if (w_doAccess && !w_reject && w_misaligned) w_nextState = SPLIT;
            SPLIT:   w_nextState = IDLE;
            default: w_nextState = c_resetState;
        endcase
    end

    // FSM outputs: bank write/read strobes, indices and write bytes
    always_comb begin
        w_weE  = 1'b0;
        w_weO  = 1'b0;
        w_reE  = 1'b0;
        w_reO  = 1'b0;
        w_idxE = w_wordIdx;
        w_idxO = w_wordIdx;
        w_wdE  = WriteData[15:8];
        w_wdO  = WriteData[7:0];
        case (r_state)
            INIT: begin
                w_weE  = 1'b1;
                w_weO  = 1'b1;
                w_idxE = r_clearIdx;
                w_idxO = r_clearIdx;
                w_wdE  = 8'h00;
                w_wdO  = 8'h00;
            end
            IDLE: begin
                if (w_doAccess && !w_reject) begin
                    if (Size == SIZE_BYTE) begin
                        // A single byte always travels on WriteData[7:0]
                        w_wdE = WriteData[7:0];
                        if (w_oddAddr) begin
                            w_weO = w_isWrite;
                            w_reO = w_isRead;
                        end else begin
                            w_weE = w_isWrite;
                            w_reE = w_isRead;
                        end
                    end else if (!w_oddAddr) begin
                        w_weE = w_isWrite;
                        w_weO = w_isWrite;
                        w_reE = w_isRead;
                        w_reO = w_isRead;
                    end else begin
                        // Misaligned word, first half: MSB lives in the odd bank
                        w_wdO = WriteData[15:8];
                        w_weO = w_isWrite;
                        w_reO = w_isRead;
                    end
                end
            end
            SPLIT: begin
                // Second half: LSB lives in the next even-bank entry
                w_idxE = r_splitIdx;
                w_wdE  = r_splitByte;
                w_weE  = ~r_splitRead;
                w_reE  = r_splitRead;
            end
            default: ;
        endcase
    end

    // Zero-fill sweep index, advanced once per INIT cycle
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_clearIdx <= '0;
        end else if (r_state == INIT) begin
            r_clearIdx <= r_clearIdx + c_idxW'(1);
        end
    end

    // Ready is registered so it stays low throughout reset
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= (w_nextState == IDLE);
        end
    end

    // Result strobes, read-format selection and misaligned-access bookkeeping
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_readValid <= 1'b0;
            r_addrError <= 1'b0;
            r_fmt       <= FMT_ZERO;
            r_holdData  <= 16'h0000;
            r_splitIdx  <= '0;
            r_splitByte <= 8'h00;
            r_splitRead <= 1'b0;
        end else begin
            r_readValid <= 1'b0;
            r_addrError <= 1'b0;
            if (r_state == IDLE && w_doAccess) begin
                if (w_reject) begin
                    r_addrError <= 1'b1;
                    if (w_isRead) begin
                        r_readValid <= 1'b1;
                        r_fmt       <= FMT_ZERO;
                    end
                end else if (w_misaligned) begin
                    r_splitIdx  <= w_wordIdx + c_idxW'(1);
                    r_splitByte <= WriteData[7:0];
                    r_splitRead <= w_isRead;
                    if (w_isRead) begin
                        // The odd-bank register changes now; freeze the visible
                        // result until the full word is assembled.
                        r_holdData <= w_readData;
                        r_fmt      <= FMT_HOLD;
                    end
                end else if (w_isRead) begin
                    r_readValid <= 1'b1;
                    if (!w_isWord) begin
                        r_fmt <= w_oddAddr ? FMT_BYTE_O : FMT_BYTE_E;
                    end else begin
                        r_fmt <= FMT_WORD_EO;
                    end
                end
            end else if (r_state == SPLIT && r_splitRead) begin
                r_readValid <= 1'b1;
                r_fmt       <= FMT_WORD_OE;
            end
        end
    end

    // Assemble ReadData from the bank read registers
    always_comb begin
        w_readData = 16'h0000;
        case (r_fmt)
            FMT_BYTE_E:  w_readData = {8'h00, w_rdE};
            FMT_BYTE_O:  w_readData = {8'h00, w_rdO};
            FMT_WORD_EO: w_readData = {w_rdE, w_rdO};
            FMT_WORD_OE: w_readData = {w_rdO, w_rdE};
            FMT_HOLD:    w_readData = r_holdData;
            default:     w_readData = 16'h0000;
        endcase
    end

    dmem_bank #(
        .ENTRIES (c_entries),
        .IDX_W   (c_idxW)
    ) u_bankEven (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .WriteEn   (w_weE),
        .ReadEn    (w_reE),
        .Index     (w_idxE),
        .WriteByte (w_wdE),
        .ReadByte  (w_rdE)
    );

    dmem_bank #(
        .ENTRIES (c_entries),
        .IDX_W   (c_idxW)
    ) u_bankOdd (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .WriteEn   (w_weO),
        .ReadEn    (w_reO),
        .Index     (w_idxO),
        .WriteByte (w_wdO),
        .ReadByte  (w_rdO)
    );

    assign Ready     = r_ready;
    assign ReadData  = w_readData;
    assign ReadValid = r_readValid;
    assign AddrError = r_addrError;

endmodule : banked_data_memory
`default_nettype wire

// File: tb/tb_banked_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_banked_data_memory
// Description : Self-checking bench for banked_data_memory. A byte-array
//               reference model predicts every read result, error strobe and
//               Ready behaviour; stimulus mixes directed cases and $urandom.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_banked_data_memory;

    localparam int DEPTH = 256;

    logic        Clock     = 1'b0;
    logic        Reset_n   = 1'b0;
    logic        Req       = 1'b0;
    logic        MemWrite  = 1'b0;
    logic        MemRead   = 1'b0;
    logic        Size      = 1'b0;
    logic [15:0] Adresa    = 16'h0000;
    logic [15:0] WriteData = 16'h0000;
    logic        Ready;
    logic [15:0] ReadData;
    logic        ReadValid;
    logic        AddrError;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [7:0]  refMem [DEPTH];
    logic [15:0] lastRead;

    banked_data_memory #(
        .ADDR_W         (16),
        .DEPTH_BYTES    (DEPTH),
        .CLEAR_ON_RESET (1'b1),
        .INIT_FILE      ("")
    ) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Req       (Req),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .Size      (Size),
        .Adresa    (Adresa),
        .WriteData (WriteData),
        .Ready     (Ready),
        .ReadData  (ReadData),
        .ReadValid (ReadValid),
        .AddrError (AddrError)
    );

    always #5 Clock = ~Clock;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < DEPTH; i++) refMem[i] = 8'h00;
        lastRead = 16'h0000;
    endtask

    task automatic waitReady();
        int n = 0;
        while (Ready !== 1'b1 && n < 400) begin
            @(posedge Clock); #1;
            n++;
        end
        if (Ready !== 1'b1) checkValue("ready_timeout", {31'd0, Ready}, 32'd1);
    endtask

    // Count cycles from reset release until Ready rises
    task automatic expectInit(input string tag);
        int cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge Clock); #1;
            cnt++;
            if (Ready === 1'b1) break;
        end
        checkValue(tag, cnt, DEPTH / 2);
    endtask

    // One request, judged against the byte-array model
    task automatic access(input logic wr, input logic rd, input logic sz,
                          input logic [15:0] a, input logic [15:0] wd);
        int   ai;
        int   lastByte;
        bit   active;
        bit   reject;
        bit   split;
        bit   isRead;
        waitReady();
        ai       = int'(a);
        active   = wr | rd;
        lastByte = ai + (sz ? 1 : 0);
        reject   = active && (lastByte >= DEPTH);
        split    = active && !reject && sz && a[0];
        isRead   = rd && !wr;

        Req = 1'b1; MemWrite = wr; MemRead = rd; Size = sz; Adresa = a; WriteData = wd;
        @(posedge Clock); #1;
        Req = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;

        if (split) begin
            checkValue("split_ready", {31'd0, Ready}, 32'd0);
            checkValue("split_valid", {31'd0, ReadValid}, 32'd0);
            checkValue("split_hold", {16'd0, ReadData}, {16'd0, lastRead});
            @(posedge Clock); #1;
        end

        if (isRead) begin
            if (reject)  lastRead = 16'h0000;
            else if (sz) lastRead = {refMem[ai], refMem[ai + 1]};
            else         lastRead = {8'h00, refMem[ai]};
        end
        if (wr && !reject) begin
            if (sz) begin
                refMem[ai]     = wd[15:8];
                refMem[ai + 1] = wd[7:0];
            end else begin
                refMem[ai] = wd[7:0];
            end
        end

        checkValue("read_valid", {31'd0, ReadValid}, {31'd0, isRead});
        checkValue("addr_error", {31'd0, AddrError}, {31'd0, reject});
        checkValue("read_data", {16'd0, ReadData}, {16'd0, lastRead});
        checkValue("ready_after", {31'd0, Ready}, 32'd1);
    endtask

    // A cycle with no request: strobes low, ReadData held
    task automatic idleCycle();
        @(posedge Clock); #1;
        checkValue("idle_valid", {31'd0, ReadValid}, 32'd0);
        checkValue("idle_err", {31'd0, AddrError}, 32'd0);
        checkValue("idle_hold", {16'd0, ReadData}, {16'd0, lastRead});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected finish before 500000");
        $fatal(1);
    end

    initial begin
        logic        wr;
        logic        rd;
        logic        sz;
        logic [15:0] a;
        logic [15:0] wd;

        clearModel();
        #3;
        checkValue("rst_ready", {31'd0, Ready}, 32'd0);
        checkValue("rst_valid", {31'd0, ReadValid}, 32'd0);
        checkValue("rst_err", {31'd0, AddrError}, 32'd0);
        checkValue("rst_data", {16'd0, ReadData}, 32'd0);
        #9 Reset_n = 1'b1;
        expectInit("init_cycles");

        // Cleared memory reads zero
        access(1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000);

        // Big-endian word write, byte read-back
        access(1'b1, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
        access(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        access(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000);
        idleCycle();

        // Misaligned word write and read
        access(1'b1, 1'b0, 1'b1, 16'h0021, 16'h1234);
        access(1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000);
        access(1'b0, 1'b1, 1'b0, 16'h0022, 16'h0000);
        access(1'b0, 1'b1, 1'b1, 16'h0021, 16'h0000);
        idleCycle();

        // Range boundaries
        access(1'b1, 1'b0, 1'b0, 16'h00FF, 16'h0077);
        access(1'b1, 1'b0, 1'b1, 16'h00FF, 16'hDEAD);
        access(1'b0, 1'b1, 1'b0, 16'h00FF, 16'h0000);
        access(1'b0, 1'b1, 1'b1, 16'h0100, 16'h0000);
        idleCycle();
        access(1'b1, 1'b0, 1'b1, 16'h00FE, 16'h4321);
        access(1'b0, 1'b1, 1'b1, 16'h00FE, 16'h0000);
        access(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000);

        // Write wins when both MemWrite and MemRead are set
        access(1'b1, 1'b1, 1'b1, 16'h0002, 16'hA5A5);
        access(1'b0, 1'b1, 1'b1, 16'h0002, 16'h0000);

        // Randomized traffic over a small window plus the top boundary
        for (int i = 0; i < 400; i++) begin
            wr = 1'(($urandom & 32'h3) == 0);
            rd = 1'(($urandom & 32'h3) != 0);
            sz = 1'($urandom & 32'h1);
            wd = 16'($urandom);
            if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(248, 264));
            else                           a = 16'($urandom_range(0, 63));
            access(wr, rd, sz, a, wd);
            if ($urandom_range(0, 7) == 0) idleCycle();
        end

        // Reset in the middle of a misaligned write
        waitReady();
        Req = 1'b1; MemWrite = 1'b1; MemRead = 1'b0; Size = 1'b1;
        Adresa = 16'h0031; WriteData = 16'h5A3C;
        @(posedge Clock); #1;
        Req = 1'b0; MemWrite = 1'b0;
        checkValue("pre_abort_ready", {31'd0, Ready}, 32'd0);
        Reset_n = 1'b0;
        #1;
        checkValue("abort_ready", {31'd0, Ready}, 32'd0);
        checkValue("abort_valid", {31'd0, ReadValid}, 32'd0);
        checkValue("abort_err", {31'd0, AddrError}, 32'd0);
        checkValue("abort_data", {16'd0, ReadData}, 32'd0);
        clearModel();
        #10 Reset_n = 1'b1;
        expectInit("reinit_cycles");
        access(1'b0, 1'b1, 1'b1, 16'h0030, 16'h0000);
        access(1'b0, 1'b1, 1'b1, 16'h0032, 16'h0000);
        access(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000);
        access(1'b0, 1'b1, 1'b0, 16'h00FF, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_banked_data_memory
`default_nettype wire

// File: doc/banked_data_memory.md
BANKED_DATA_MEMORY -- requirements
Module: banked_data_memory

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named Clock and Reset_n.
REQ-002 Parameter ADDR_W, default 16: byte-address width.
REQ-003 Parameter DEPTH_BYTES, default 256: byte capacity; must be an even power of two no greater than 2**ADDR_W.
REQ-004 Parameter CLEAR_ON_RESET, default 1: when 1, zero-fill the memory after every reset.
REQ-005 Parameter INIT_FILE, default "": hex byte image loaded at time zero; used only when CLEAR_ON_RESET=0.
REQ-006 Clock  in  1  rising-edge clock.
REQ-007 Reset_n  in  1  asynchronous active-low reset.
REQ-008 Req  in  1  access request.
REQ-009 MemWrite  in  1  write access.
REQ-010 MemRead  in  1  read access.
REQ-011 Size  in  1  0 = byte access, 1 = word access.
REQ-012 Adresa  in  ADDR_W  byte address.
REQ-013 WriteData  in  16  write data; byte access uses [7:0].
REQ-014 Ready  out  1  block can accept a request this cycle.
REQ-015 ReadData  out  16  registered read result.
REQ-016 ReadValid  out  1  one-cycle strobe marking ReadData valid.
REQ-017 AddrError  out  1  one-cycle strobe marking a rejected access.

Function
REQ-018 Storage SHALL be two byte-wide banks: even bytes at index A>>1 in bank E, odd bytes at index A>>1 in bank O.
REQ-019 Byte order SHALL be big-endian: byte A is ReadData[15:8] and byte A+1 is ReadData[7:0].
REQ-020 A request SHALL be accepted only on a rising edge where Req=1 and Ready=1; Req with Ready=0 is ignored, not queued.
REQ-021 If MemWrite=1 and MemRead=1, the access is a write and no ReadValid is produced.
REQ-022 If MemWrite=0 and MemRead=0, the request is a no-op.
REQ-023 FSM states: INIT, IDLE, SPLIT.
REQ-024 INIT: Ready=0; a counter zeroes word index k (both banks) each cycle for k = 0 .. DEPTH_BYTES/2-1, then the FSM enters IDLE.
REQ-025 INIT duration SHALL be exactly DEPTH_BYTES/2 cycles.
REQ-026 When CLEAR_ON_RESET=0, reset SHALL go directly to IDLE and memory contents SHALL be preserved.
REQ-027 IDLE: Ready=1.
REQ-028 Aligned word access or byte access SHALL complete in one cycle.
REQ-029 For a read, ReadData and ReadValid=1 SHALL appear on the cycle after acceptance.
REQ-030 Byte reads SHALL return {8'h00, byte}.
REQ-031 Misaligned word access (Size=1, Adresa[0]=1) SHALL: accept cycle writes/reads O[A>>1] (MSB); FSM enters SPLIT with Ready=0; SPLIT cycle writes/reads E[(A>>1)+1] (LSB); then return to IDLE. Read result is valid the cycle after SPLIT.
REQ-032 Throughput SHALL be one request per cycle in IDLE; a misaligned word costs two cycles.
REQ-033 Range check: reject if A >= DEPTH_BYTES, or if word access and A+1 >= DEPTH_BYTES; addresses do not wrap.
REQ-034 A rejected access SHALL write nothing and pulse AddrError the next cycle; a rejected read also pulses ReadValid with ReadData=16'h0000.
REQ-035 ReadData SHALL hold its last value while ReadValid=0.
REQ-036 Reset asserted during SPLIT SHALL abort the access; the MSB byte may already be written and the LSB byte is not written.

Reset
REQ-037 Reset_n=0 SHALL asynchronously force: state=INIT (or IDLE when CLEAR_ON_RESET=0), Ready=0, ReadValid=0, AddrError=0, ReadData=16'h0000, clear counter=0.
REQ-038 Memory contents SHALL NOT be reset asynchronously; clearing happens only via INIT.

Structure
REQ-039 Package dmem_pkg SHALL hold the state enum (INIT, IDLE, SPLIT) and the constants SIZE_BYTE=1'b0, SIZE_WORD=1'b1.
REQ-040 Sub-module dmem_bank (byte-wide synchronous-write RAM, DEPTH_BYTES/2 entries, registered read) SHALL be instantiated twice.

Verification
REQ-041 Reset, DEPTH_BYTES=256 -> Ready=0 for 128 cycles, then 1; a word read of 0x0040 returns 16'h0000.
REQ-042 Word write 0x0010 = 16'hBEEF; byte read 0x0010 -> 16'h00BE; byte read 0x0011 -> 16'h00EF.
REQ-043 Word write 0x0021 = 16'h1234 -> Ready=0 for one cycle; byte 0x0021 = 8'h12, byte 0x0022 = 8'h34; word read 0x0021 -> 16'h1234 with a single ReadValid.
REQ-044 Word write 0x00FF -> AddrError pulse and no memory change; word read 0x0100 -> AddrError=1, ReadValid=1, ReadData=16'h0000.
REQ-045 MemWrite=1 and MemRead=1 at 0x0002 with data 16'hA5A5 -> data written, no ReadValid.
REQ-046 Reset_n dropped during SPLIT of a write to 0x0031 -> state=INIT, outputs zero, memory cleared after 128 cycles.
